// File: rtl/sha256_job_sched.sv
// Round-robin job scheduler that time-shares one simplified_sha256 core.
// One job in flight; a watchdog aborts jobs the core never finishes.
module sha256_job_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2047,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*16-1:0] req_msg_addr,
    input  logic [NUM_REQ*16-1:0] req_out_addr,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  core_start,
    output logic [15:0]           core_message_addr,
    output logic [15:0]           core_output_addr,
    input  logic                  core_done,
    output logic                  cmp_valid,
    output logic [ID_W-1:0]       cmp_id,
    output logic                  cmp_error,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        REPORT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cur_id;
    logic [15:0]     timer;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            grant;
    logic            wd_hit;
    logic            waiting;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign grant     = (state == IDLE) && core_done && grant_found;
    assign req_ready = grant ? (NUM_REQ'(1) << grant_id) : '0;

    assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
    // Fires on the cycle whose increment would bring timer to TIMEOUT_CYCLES-1.
    assign wd_hit  = ({1'b0, timer} + 17'd1) >= 17'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant) state_next = LAUNCH;
            end
            LAUNCH: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!core_done)  state_next = WAIT_DONE;
                else if (wd_hit) state_next = REPORT;
            end
            WAIT_DONE: begin
                if (core_done || wd_hit) state_next = REPORT;
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr            <= '0;
            cur_id            <= '0;
            timer             <= '0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
            cmp_id            <= '0;
            cmp_error         <= 1'b0;
        end else begin
            if (grant) begin
                cur_id            <= grant_id;
                core_message_addr <= req_msg_addr[{grant_id, 4'b0000} +: 16];
                core_output_addr  <= req_out_addr[{grant_id, 4'b0000} +: 16];
            end
            if (state == LAUNCH) begin
                timer <= '0;
            end else if (waiting && state_next != REPORT) begin
                timer <= timer + 16'd1;
            end
            if (waiting && state_next == REPORT) begin
                cmp_id    <= cur_id;
                // Only a done seen in WAIT_DONE is a genuine completion.
                cmp_error <= !((state == WAIT_DONE) && core_done);
            end
            if (state == REPORT) begin
                rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
            end
        end
    end

    assign core_start = (state == LAUNCH);
    assign cmp_valid  = (state == REPORT);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sha256_job_sched.sv
// Directed bench for sha256_job_sched: grants, round-robin order,
// watchdog abort, IDLE gating on core_done and mid-job reset.
module tb_sha256_job_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [63:0] req_msg_addr;
    logic [63:0] req_out_addr;
    logic [3:0]  req_ready;
    logic        core_start;
    logic [15:0] core_message_addr;
    logic [15:0] core_output_addr;
    logic        core_done;
    logic        cmp_valid;
    logic [1:0]  cmp_id;
    logic        cmp_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int cmp_cnt = 0;

    sha256_job_sched #(
        .NUM_REQ(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_msg_addr(req_msg_addr),
        .req_out_addr(req_out_addr),
        .req_ready(req_ready),
        .core_start(core_start),
        .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr),
        .core_done(core_done),
        .cmp_valid(cmp_valid),
        .cmp_id(cmp_id),
        .cmp_error(cmp_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (cmp_valid) cmp_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Called in a granting IDLE cycle; returns in the REPORT cycle.
    task automatic finish_job();
        step();
        step();
        core_done = 1'b0;
        step();
        core_done = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        req_valid    = 4'b0;
        core_done    = 1'b1;
        req_msg_addr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        req_out_addr = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
        step();
        checks++;
        if ({busy, core_start, cmp_valid, cmp_error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000",
                     {busy, core_start, cmp_valid, cmp_error});
        end
        checks++;
        if ({core_message_addr, core_output_addr, cmp_id, req_ready} !== 38'h0) begin
            errors++;
            $display("FAIL reset_values got %h %h %h %b exp all zero",
                     core_message_addr, core_output_addr, cmp_id, req_ready);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_msg_addr[15:0] = 16'h0000;
        req_out_addr[15:0] = 16'h0100;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got %b exp 0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        checks++;
        if ({core_start, busy} !== 2'b11 || core_output_addr !== 16'h0100
            || core_message_addr !== 16'h0000) begin
            errors++;
            $display("FAIL single_launch got start %b busy %b out %h msg %h exp 1 1 0100 0000",
                     core_start, busy, core_output_addr, core_message_addr);
        end
        step();
        core_done = 1'b0;
        step();
        step();
        core_done = 1'b1;
        step();
        checks++;
        if ({cmp_valid, cmp_id, cmp_error} !== 4'b1000) begin
            errors++;
            $display("FAIL single_cmp got v %b id %0d err %b exp 1 0 0",
                     cmp_valid, cmp_id, cmp_error);
        end
        step();
        checks++;
        if ({cmp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got v %b busy %b exp 0 0", cmp_valid, busy);
        end
        req_msg_addr[15:0] = 16'h1000;
        req_out_addr[15:0] = 16'h2000;
    endtask

    task automatic test_back_to_back();
        int s0;
        do_reset();
        step();
        req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) begin
            int e;
            e  = j % 4;
            s0 = start_cnt;
            checks++;
            if (req_ready !== 4'(1 << e)) begin
                errors++;
                $display("FAIL rr_grant%0d got %b exp %b", j, req_ready, 4'(1 << e));
            end
            finish_job();
            checks++;
            if (cmp_valid !== 1'b1 || cmp_id !== 2'(e)
                || core_message_addr !== 16'h1000 + 16'(e)
                || core_output_addr !== 16'h2000 + 16'(e)
                || start_cnt - s0 != 1) begin
                errors++;
                $display("FAIL rr_job%0d got v %b id %0d msg %h out %h starts %0d exp 1 %0d %h %h 1",
                         j, cmp_valid, cmp_id, core_message_addr, core_output_addr,
                         start_cnt - s0, e, 16'h1000 + 16'(e), 16'h2000 + 16'(e));
            end
            step();
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_pointer();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL ptr_grant2 got %b exp 0100", req_ready);
        end
        finish_job();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL ptr_grant3 got %b exp 1000", req_ready);
        end
        finish_job();
        checks++;
        if (cmp_id !== 2'd3) begin
            errors++;
            $display("FAIL ptr_cmp3 got %0d exp 3", cmp_id);
        end
        step();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_grant0 got %b exp 0001", req_ready);
        end
        finish_job();
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_watchdog();
        int s0;
        int hit;
        req_valid = 4'b0010;
        core_done = 1'b1;
        s0 = start_cnt;
        step();
        req_valid = 4'b0000;
        hit = 0;
        for (int k = 1; k <= 40 && hit == 0; k++) begin
            step();
            if (cmp_valid === 1'b1) hit = k;
        end
        checks++;
        if (hit != 16) begin
            errors++;
            $display("FAIL wd_latency got %0d exp 16", hit);
        end
        checks++;
        if ({cmp_id, cmp_error} !== 3'b011 || start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL wd_cmp got id %0d err %b starts %0d exp 1 1 1",
                     cmp_id, cmp_error, start_cnt - s0);
        end
        step();
        checks++;
        if ({cmp_valid, cmp_error, busy} !== 3'b010) begin
            errors++;
            $display("FAIL wd_hold got v %b err %b busy %b exp 0 1 0",
                     cmp_valid, cmp_error, busy);
        end
    endtask

    task automatic test_done_low_idle();
        int bad;
        int s0;
        core_done = 1'b0;
        req_valid = 4'b0010;
        s0  = start_cnt;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (req_ready !== 4'b0 || busy !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0 || start_cnt != s0) begin
            errors++;
            $display("FAIL idle_gate got bad %0d starts %0d exp 0 0", bad, start_cnt - s0);
        end
        core_done = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL idle_release got %b exp 0010", req_ready);
        end
        finish_job();
        req_valid = 4'b0000;
        checks++;
        if ({cmp_valid, cmp_id, cmp_error} !== 4'b1010) begin
            errors++;
            $display("FAIL idle_cmp got v %b id %0d err %b exp 1 1 0",
                     cmp_valid, cmp_id, cmp_error);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int c0;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        step();
        core_done = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, core_start, cmp_id} !== 4'b0 || core_message_addr !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got busy %b start %b id %0d msg %h exp 0 0 0 0000",
                     busy, core_start, cmp_id, core_message_addr);
        end
        c0 = cmp_cnt;
        step();
        core_done = 1'b1;
        reset_n = 1'b1;
        step();
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr got %b exp 0001", req_ready);
        end
        finish_job();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mid_grant2 got %b exp 0100", req_ready);
        end
        finish_job();
        req_valid = 4'b0000;
        checks++;
        if (cmp_id !== 2'd2 || core_message_addr !== 16'h1002) begin
            errors++;
            $display("FAIL mid_cmp2 got id %0d msg %h exp 2 1002", cmp_id, core_message_addr);
        end
        step();
        checks++;
        if (cmp_cnt - c0 != 2) begin
            errors++;
            $display("FAIL mid_stale got %0d completions exp 2", cmp_cnt - c0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout reached exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_pointer();
        test_watchdog();
        test_done_low_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
